// File: rtl/fault_map_collector.sv
// fault_map_collector: captures per-row PE fault bits, folds in row/column faults,
// counts faulty PEs and streams the final map out row by row under ready/valid.
module fault_map_collector #(
   parameter int SYSTOLIC_SIZE = 8,
   parameter int IDX_W = $clog2(SYSTOLIC_SIZE),
   parameter int CNT_W = $clog2(SYSTOLIC_SIZE*SYSTOLIC_SIZE+1)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [SYSTOLIC_SIZE-1:0] pe_detection,
   input  logic [SYSTOLIC_SIZE-1:0] row_fault_detection,
   input  logic [SYSTOLIC_SIZE-1:0] column_fault_detection,
   output logic                     busy,
   output logic                     done,
   output logic                     map_valid,
   input  logic                     map_ready,
   output logic [IDX_W-1:0]         map_row,
   output logic [SYSTOLIC_SIZE-1:0] map_data,
   output logic [SYSTOLIC_SIZE-1:0] faulty_row_mask,
   output logic [SYSTOLIC_SIZE-1:0] faulty_col_mask,
   output logic [CNT_W-1:0]         fault_count
);
   localparam int N = SYSTOLIC_SIZE;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(N-1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(N*N);

   typedef enum logic [2:0] {IDLE, CAPTURE, MERGE, DRAIN, FINISH} state_t;

   state_t           state;
   logic [IDX_W-1:0] k;
   logic [N-1:0]     map [N];
   logic [N-1:0]     merged;
   logic [CNT_W-1:0] pop;
   logic [CNT_W:0]   sum;
   logic [CNT_W-1:0] sat;

   // a faulty row kills every PE in it; otherwise faulty columns are OR-ed in
   assign merged = faulty_row_mask[k] ? '1 : (map[k] | faulty_col_mask);
   assign sum = {1'b0, fault_count} + {1'b0, pop};
   assign sat = (sum > (CNT_W+1)'(N*N)) ? MAX_CNT : sum[CNT_W-1:0];

   always_comb begin
      pop = '0;
      for (int i = 0; i < N; i++) pop = pop + CNT_W'(merged[i]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         k <= '0;
         map <= '{default: '0};
         faulty_row_mask <= '0;
         faulty_col_mask <= '0;
         fault_count <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         map_valid <= 1'b0;
         map_row <= '0;
         map_data <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               map <= '{default: '0};
               faulty_row_mask <= '0;
               faulty_col_mask <= '0;
               fault_count <= '0;
               k <= '0;
               busy <= 1'b1;
               state <= CAPTURE;
            end
            CAPTURE: begin
               map[k] <= pe_detection;
               faulty_row_mask <= faulty_row_mask | row_fault_detection;
               faulty_col_mask <= faulty_col_mask | column_fault_detection;
               k <= (k == LAST) ? '0 : k + 1'b1;
               if (k == LAST) state <= MERGE;
            end
            MERGE: begin
               map[k] <= merged;
               fault_count <= sat;
               k <= (k == LAST) ? '0 : k + 1'b1;
               // row 0 was finalised N-1 cycles ago, so it can be presented at once
               if (k == LAST) begin
                  state <= DRAIN;
                  map_valid <= 1'b1;
                  map_row <= '0;
                  map_data <= map[0];
               end
            end
            DRAIN: if (map_ready) begin
               if (k == LAST) begin
                  state <= FINISH;
                  k <= '0;
                  map_valid <= 1'b0;
                  map_row <= '0;
                  map_data <= '0;
                  done <= 1'b1;
               end else begin
                  k <= k + 1'b1;
                  map_row <= k + 1'b1;
                  map_data <= map[k + 1'b1];
               end
            end
            FINISH: begin
               busy <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fault_map_collector.sv
// tb_fault_map_collector: scoreboard bench; a behavioural model queues the expected
// map rows per pass and the drain loop pops and compares them as the DUT emits.
module tb_fault_map_collector;
   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         map_ready = 1'b0;
   logic [N-1:0] pe_detection = '0;
   logic [N-1:0] row_fault_detection = '0;
   logic [N-1:0] column_fault_detection = '0;
   logic         busy, done, map_valid;
   logic [2:0]   map_row;
   logic [N-1:0] map_data, faulty_row_mask, faulty_col_mask;
   logic [6:0]   fault_count;

   typedef struct {
      logic [2:0]   row;
      logic [N-1:0] data;
   } exp_t;

   exp_t         exp_q[$];
   logic [N-1:0] stim_pe [N];
   logic [N-1:0] stim_row [N];
   logic [N-1:0] stim_col [N];
   logic [N-1:0] exp_rm, exp_cm;
   int           exp_cnt;
   int           busy_cnt;
   int           n_cmp = 0;
   int           n_fail = 0;

   fault_map_collector #(.SYSTOLIC_SIZE(N)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .pe_detection(pe_detection), .row_fault_detection(row_fault_detection),
      .column_fault_detection(column_fault_detection),
      .busy(busy), .done(done), .map_valid(map_valid), .map_ready(map_ready),
      .map_row(map_row), .map_data(map_data),
      .faulty_row_mask(faulty_row_mask), .faulty_col_mask(faulty_col_mask),
      .fault_count(fault_count)
   );

   always #5 clk = ~clk;

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_stim;
      for (int i = 0; i < N; i++) begin
         stim_pe[i] = '0;
         stim_row[i] = '0;
         stim_col[i] = '0;
      end
   endtask

   // expected final map straight from the capture/merge rules
   task automatic model;
      logic [N-1:0] v;
      exp_rm = '0;
      exp_cm = '0;
      exp_cnt = 0;
      for (int i = 0; i < N; i++) begin
         exp_rm = exp_rm | stim_row[i];
         exp_cm = exp_cm | stim_col[i];
      end
      for (int r = 0; r < N; r++) begin
         v = exp_rm[r] ? '1 : (stim_pe[r] | exp_cm);
         exp_cnt += $countones(v);
         exp_q.push_back('{row: 3'(r), data: v});
      end
      if (exp_cnt > N*N) exp_cnt = N*N;
   endtask

   // cycle 1 carries start, cycles 2..N+1 are the capture slots
   task automatic drive_cycle(input int cyc, input bit repulse);
      int idx;
      idx = (cyc >= 2 && cyc <= N+1) ? cyc - 2 : 0;
      start = (cyc == 1) || (repulse && (cyc == 4 || cyc == 13));
      pe_detection = (cyc >= 2 && cyc <= N+1) ? stim_pe[idx] : '0;
      row_fault_detection = (cyc >= 2 && cyc <= N+1) ? stim_row[idx] : '0;
      column_fault_detection = (cyc >= 2 && cyc <= N+1) ? stim_col[idx] : '0;
   endtask

   task automatic run_pass(input string name, input int mode, input bit repulse, output int lat);
      int d, n_done, bad_data, extra;
      model();
      d = 0; n_done = 0; bad_data = 0; extra = 0; lat = 0; busy_cnt = 0;
      for (int cyc = 1; cyc <= 200 && lat == 0; cyc++) begin
         drive_cycle(cyc, repulse);
         map_ready = (mode == 0) || (d % 3 == 0);
         if (busy) busy_cnt++;
         if (done) begin
            n_done++;
            lat = cyc;
         end
         if (!map_valid && map_data !== '0) bad_data++;
         if (map_valid) begin
            d++;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL %s extra_row: got row %0d data %h, required none", name, map_row, map_data);
            end else begin
               if (map_row !== exp_q[0].row || map_data !== exp_q[0].data) begin
                  n_fail++;
                  $display("FAIL %s row_data: got row %0d data %h, required row %0d data %h",
                           name, map_row, map_data, exp_q[0].row, exp_q[0].data);
               end
               if (map_ready) void'(exp_q.pop_front());
            end
         end
         next_cycle();
      end
      start = 1'b0;
      map_ready = 1'b0;
      n_cmp++;
      if (lat == 0) begin
         n_fail++;
         $display("FAIL %s done_timeout: got no done within 200 cycles, required done", name);
      end
      for (int i = 0; i < 30; i++) begin
         if (busy || done) extra++;
         if (map_valid || map_data !== '0) bad_data++;
         next_cycle();
      end
      n_cmp++;
      if (n_done != 1 || extra != 0) begin
         n_fail++;
         $display("FAIL %s single_done: got %0d dones, %0d idle-busy cycles, required 1 and 0", name, n_done, extra);
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s rows_missing: got %0d rows undelivered, required 0", name, exp_q.size());
         exp_q.delete();
      end
      n_cmp++;
      if (bad_data != 0) begin
         n_fail++;
         $display("FAIL %s data_when_invalid: got %0d nonzero cycles, required 0", name, bad_data);
      end
      n_cmp++;
      if (fault_count !== 7'(exp_cnt)) begin
         n_fail++;
         $display("FAIL %s fault_count: got %0d, required %0d", name, fault_count, exp_cnt);
      end
      n_cmp++;
      if (faulty_row_mask !== exp_rm || faulty_col_mask !== exp_cm) begin
         n_fail++;
         $display("FAIL %s masks: got row %h col %h, required row %h col %h",
                  name, faulty_row_mask, faulty_col_mask, exp_rm, exp_cm);
      end
   endtask

   task automatic check_zeroed(input string name);
      n_cmp++;
      if ({busy, done, map_valid, map_row, map_data, faulty_row_mask, faulty_col_mask, fault_count} !== '0) begin
         n_fail++;
         $display("FAIL %s reset_outputs: got busy %b done %b valid %b row %0d data %h rm %h cm %h cnt %0d, required all 0",
                  name, busy, done, map_valid, map_row, map_data, faulty_row_mask, faulty_col_mask, fault_count);
      end
   endtask

   task automatic test_reset;
      repeat (3) next_cycle();
      check_zeroed("reset");
      rst_n = 1'b1;
      repeat (5) next_cycle();
      n_cmp++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset no_self_start: got busy %b, required 0", busy);
      end
   endtask

   task automatic test_all_zero;
      int lat;
      clear_stim();
      run_pass("all_zero", 0, 0, lat);
      n_cmp++;
      if (lat != 26 || busy_cnt != 25) begin
         n_fail++;
         $display("FAIL all_zero latency: got done at cycle %0d busy %0d cycles, required 26 and 25", lat, busy_cnt);
      end
   endtask

   task automatic test_single_pe;
      int lat;
      clear_stim();
      stim_pe[3] = 8'h04;
      run_pass("single_pe", 0, 0, lat);
   endtask

   task automatic test_row_col;
      int lat;
      clear_stim();
      stim_col[1] = 8'h81;
      stim_row[6] = 8'h20;
      run_pass("row_col", 0, 0, lat);
      n_cmp++;
      if (fault_count !== 7'd22) begin
         n_fail++;
         $display("FAIL row_col count22: got %0d, required 22", fault_count);
      end
   endtask

   task automatic test_stall;
      int lat;
      for (int i = 0; i < N; i++) begin
         stim_pe[i] = N'($urandom);
         stim_row[i] = '0;
         stim_col[i] = '0;
      end
      stim_col[5] = 8'h10;
      run_pass("stall", 1, 0, lat);
   endtask

   task automatic test_restart_ignored;
      int lat;
      clear_stim();
      stim_pe[0] = 8'h01;
      stim_pe[7] = 8'hC0;
      stim_row[2] = 8'h02;
      run_pass("restart_ignored", 0, 1, lat);
   endtask

   task automatic test_saturate;
      int lat;
      clear_stim();
      stim_row[4] = 8'hFF;
      stim_col[0] = 8'hFF;
      stim_pe[1] = 8'h55;
      run_pass("saturate", 0, 0, lat);
      n_cmp++;
      if (fault_count !== 7'd64) begin
         n_fail++;
         $display("FAIL saturate count64: got %0d, required 64", fault_count);
      end
   endtask

   task automatic test_mid_reset;
      int lat;
      clear_stim();
      stim_row[0] = 8'h11;
      stim_col[3] = 8'h42;
      stim_pe[6] = 8'h3C;
      for (int cyc = 1; cyc <= 14; cyc++) begin
         drive_cycle(cyc, 0);
         if (cyc < 14) next_cycle();
      end
      start = 1'b0;
      rst_n = 1'b0;
      #1;
      check_zeroed("mid_reset");
      next_cycle();
      rst_n = 1'b1;
      repeat (4) next_cycle();
      n_cmp++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset no_self_start: got busy %b, required 0", busy);
      end
      clear_stim();
      stim_pe[2] = 8'h80;
      run_pass("after_reset", 0, 0, lat);
   endtask

   task automatic test_back_to_back;
      int lat;
      clear_stim();
      stim_pe[5] = 8'hA5;
      stim_col[7] = 8'h02;
      run_pass("back_to_back_a", 0, 0, lat);
      clear_stim();
      stim_pe[1] = 8'h18;
      run_pass("back_to_back_b", 1, 0, lat);
   endtask

   initial begin
      test_reset();
      test_all_zero();
      test_single_pe();
      test_row_col();
      test_stall();
      test_restart_ignored();
      test_saturate();
      test_mid_reset();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
